fb_reader: RTL and testbench



---
 rtl/fb_reader.sv | 201 ++++++++++++++++++++
 tb/tb_fb_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_reader.sv
// -----------------------------------------------------------------------------
// fb_reader
//
// Wishbone classic read master that walks a 16-bit framebuffer in raster
// order and hands the pixels to the display side as a valid/ready stream. A
// show-ahead FIFO absorbs bus latency and arbitration gaps.
// Byte address of pixel (x,y) is 2*(HDISP*y + x).
//
// Parameters
//   HDISP       pixels per line
//   VDISP       lines per frame
//   FIFO_DEPTH  FIFO entries, power of two, >= 4
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          1 = new bus requests may be issued
//   wb_*            Wishbone classic master, read-only, one transfer in flight
//   pix_data/sof    head-of-FIFO pixel and its start-of-frame flag
//   pix_valid       FIFO not empty
//   pix_ready       consumer accepts the head pixel when pix_valid is high
//   fifo_level      current FIFO occupancy
//
// Configuration macro
//   FB_READER_FAIRPLAY_EN  after every 64th ack the master drops cyc for one
//                          PAUSE cycle so other masters can win arbitration.
// -----------------------------------------------------------------------------
module fb_reader #(
    parameter int HDISP      = 640,
    parameter int VDISP      = 480,
    parameter int FIFO_DEPTH = 256
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    output logic [31:0]                        wb_adr,
    input  logic [15:0]                        wb_dat_sm,
    output logic [15:0]                        wb_dat_ms,
    output logic                               wb_stb,
    output logic                               wb_cyc,
    output logic                               wb_we,
    output logic [1:0]                         wb_sel,
    output logic [2:0]                         wb_cti,
    output logic [1:0]                         wb_bte,
    input  logic                               wb_ack,
    output logic [15:0]                        pix_data,
    output logic                               pix_sof,
    output logic                               pix_valid,
    input  logic                               pix_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;

`ifdef FB_READER_FAIRPLAY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_PAUSE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_REQ} state_t;
`endif

    state_t          r_state;
    logic            r_cyc;
    logic [31:0]     r_adr;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
`ifdef FB_READER_FAIRPLAY_EN
    logic [5:0]      r_ack_cnt;
`endif

    logic [16:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;

    logic            w_push;
    logic            w_pop;
    logic [LW-1:0]   w_level_next;
    logic            w_space;
    logic            w_space_next;
    logic            w_x_last;
    logic            w_y_last;
    logic [XW-1:0]   w_x_next;
    logic [YW-1:0]   w_y_next;
    logic [31:0]     w_lin_next;
    logic [16:0]     w_head;

    // Fixed bus attributes: plain single reads of a full 16-bit word.
    assign wb_dat_ms = 16'h0000;
    assign wb_we     = 1'b0;
    assign wb_sel    = 2'b11;
    assign wb_cti    = 3'b000;
    assign wb_bte    = 2'b00;
    assign wb_cyc    = r_cyc;
    assign wb_stb    = r_cyc;
    assign wb_adr    = r_adr;

    // An ack can only land in REQ, and a request is only raised with a free
    // slot, so a push never meets a full FIFO.
    assign w_push       = (r_state == ST_REQ) && wb_ack;
    assign w_pop        = pix_valid && pix_ready;
    assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);
    assign w_space      = r_level < LW'(FIFO_DEPTH);
    assign w_space_next = w_level_next < LW'(FIFO_DEPTH);

    // Raster position of the pixel after the one being acknowledged.
    assign w_x_last   = (r_x == XW'(HDISP - 1));
    assign w_y_last   = (r_y == YW'(VDISP - 1));
    assign w_x_next   = w_x_last ? '0 : r_x + 1'b1;
    assign w_y_next   = !w_x_last ? r_y : (w_y_last ? '0 : r_y + 1'b1);
    assign w_lin_next = 32'(HDISP) * 32'(w_y_next) + 32'(w_x_next);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every state register uses <= so all flops update together from
        // values sampled before the edge; = here would create ordering races.
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cyc   <= 1'b0;
            r_adr   <= '0;
            r_x     <= '0;
            r_y     <= '0;
`ifdef FB_READER_FAIRPLAY_EN
            r_ack_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_space) begin
                        r_state <= ST_REQ;
                        r_cyc   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (wb_ack) begin
                        r_x   <= w_x_next;
                        r_y   <= w_y_next;
                        r_adr <= {w_lin_next[30:0], 1'b0};
`ifdef FB_READER_FAIRPLAY_EN
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                        if (r_ack_cnt == 6'd63) begin
                            r_state <= ST_PAUSE;
                            r_cyc   <= 1'b0;
                        end else
`endif
                        if (enable && w_space_next) begin
                            r_state <= ST_REQ;
                            r_cyc   <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_cyc   <= 1'b0;
                        end
                    end
                end
`ifdef FB_READER_FAIRPLAY_EN
                ST_PAUSE: begin
                    if (enable && w_space) begin
                        r_state <= ST_REQ;
                        r_cyc   <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cyc   <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers and level, and leaving the array out of reset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {(r_x == '0) && (r_y == '0), wb_dat_sm};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_level <= w_level_next;
        end
    end

    // Show-ahead head; forced to zero while empty so stale RAM never shows.
    assign w_head     = r_mem[r_rptr];
    assign pix_valid  = (r_level != '0);
    assign pix_data   = pix_valid ? w_head[15:0] : 16'h0000;
    assign pix_sof    = pix_valid && w_head[16];
    assign fifo_level = r_level;

endmodule

// File: tb/tb_fb_reader.sv
// -----------------------------------------------------------------------------
// tb_fb_reader
//
// Bench for fb_reader with a 4x2 frame and a 256-entry FIFO. A Wishbone slave
// model returns adr[16:1] after a programmable number of wait cycles. Every ack
// pushes the expected pixel (computed from the bench's own pixel counter) into
// a queue; an independent monitor pops and compares on each pix handshake.
// -----------------------------------------------------------------------------
module tb_fb_reader;

    localparam int HDISP      = 4;
    localparam int VDISP      = 2;
    localparam int FIFO_DEPTH = 256;
    localparam int LW         = $clog2(FIFO_DEPTH + 1);
    localparam int FRAME      = HDISP * VDISP;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           pix_ready = 1'b0;
    logic [31:0]    wb_adr;
    logic [15:0]    wb_dat_sm;
    logic [15:0]    wb_dat_ms;
    logic           wb_stb;
    logic           wb_cyc;
    logic           wb_we;
    logic [1:0]     wb_sel;
    logic [2:0]     wb_cti;
    logic [1:0]     wb_bte;
    logic           wb_ack;
    logic [15:0]    pix_data;
    logic           pix_sof;
    logic           pix_valid;
    logic [LW-1:0]  fifo_level;

    typedef struct {
        logic [15:0] data;
        logic        sof;
    } pix_t;

    pix_t exp_q[$];
    pix_t push_e;
    pix_t pop_e;

    int n_vec      = 0;
    int n_miscmp   = 0;
    int exp_idx    = 0;
    int n_acks     = 0;
    int n_sof      = 0;
    int n_cyc_low  = 0;
    int ack_delay  = 0;
    int slv_cnt;
    int stb_cycles;

    fb_reader #(
        .HDISP      (HDISP),
        .VDISP      (VDISP),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wb_adr     (wb_adr),
        .wb_dat_sm  (wb_dat_sm),
        .wb_dat_ms  (wb_dat_ms),
        .wb_stb     (wb_stb),
        .wb_cyc     (wb_cyc),
        .wb_we      (wb_we),
        .wb_sel     (wb_sel),
        .wb_cti     (wb_cti),
        .wb_bte     (wb_bte),
        .wb_ack     (wb_ack),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave: data is the word index, ack after ack_delay wait cycles.
    assign wb_dat_sm = wb_adr[16:1];
    assign wb_ack    = wb_stb && (slv_cnt >= ack_delay);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 slv_cnt <= 0;
        else if (wb_stb && !wb_ack) slv_cnt <= slv_cnt + 1;
        else                        slv_cnt <= 0;
    end

    // Scoreboard producer: each ack is the next raster pixel of the bench model.
    always @(negedge clk) begin
        if (rst_n && wb_stb && wb_ack) begin
            check("ack_adr", wb_adr, 32'(2 * (exp_idx % FRAME)));
            push_e.data = 16'(exp_idx % FRAME);
            push_e.sof  = ((exp_idx % FRAME) == 0);
            exp_q.push_back(push_e);
            exp_idx++;
            n_acks++;
        end
    end

    // Monitor: compare every accepted pixel against the queue head.
    always @(negedge clk) begin
        if (rst_n && pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miscmp++;
                $display("FAIL pix_unexpected: got data 0x%0h with nothing expected (t=%0t)", pix_data, $time);
            end else begin
                pop_e = exp_q.pop_front();
                check("pix_data", 32'(pix_data), 32'(pop_e.data));
                check("pix_sof", 32'(pix_sof), 32'(pop_e.sof));
                if (pix_sof) n_sof++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !wb_cyc) n_cyc_low++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset(input logic en, input logic rdy, input int dly);
        @(posedge clk); #1;
        rst_n     = 1'b0;
        enable    = en;
        pix_ready = rdy;
        ack_delay = dly;
        exp_q.delete();
        exp_idx   = 0;
        n_acks    = 0;
        n_sof     = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // ---------------- Reset values with enable held high ----------------
        enable    = 1'b1;
        pix_ready = 1'b1;
        ack_delay = 0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc",    32'(wb_cyc),     32'd0);
        check("rst_stb",    32'(wb_stb),     32'd0);
        check("rst_adr",    wb_adr,          32'd0);
        check("rst_valid",  32'(pix_valid),  32'd0);
        check("rst_sof",    32'(pix_sof),    32'd0);
        check("rst_data",   32'(pix_data),   32'd0);
        check("rst_level",  32'(fifo_level), 32'd0);
        check("tie_we",     32'(wb_we),      32'd0);
        check("tie_sel",    32'(wb_sel),     32'd3);
        check("tie_dat_ms", 32'(wb_dat_ms),  32'd0);
        check("tie_cti",    32'(wb_cti),     32'd0);
        check("tie_bte",    32'(wb_bte),     32'd0);
        #2 rst_n = 1'b1;
        #1 check("stb_before_edge", 32'(wb_stb), 32'd0);
        @(posedge clk); #1;
        check("stb_after_enable", 32'(wb_stb), 32'd1);
        check("cyc_after_enable", 32'(wb_cyc), 32'd1);
        check("first_adr",        wb_adr,      32'd0);

        // ---------------- Zero-wait streaming, frame wrap ----------------
        n_cyc_low = 0;
        repeat (30) @(posedge clk);
        #1;
        check("stream_acks",  32'(n_acks),     32'd30);
        check("stream_level", 32'(fifo_level), 32'd1);
        check("stream_adr",   wb_adr,          32'd12);
        check("stream_sofs",  32'(n_sof),      32'd4);
        check("stream_nolow", 32'(n_cyc_low),  32'd0);

        // ---------------- Fill with consumer stalled ----------------
        apply_reset(1'b1, 1'b0, 0);
        repeat (400) @(posedge clk);
        #1;
        check("fill_acks",  32'(n_acks),     32'd256);
        check("fill_level", 32'(fifo_level), 32'd256);
        check("fill_cyc",   32'(wb_cyc),     32'd0);
        check("fill_valid", 32'(pix_valid),  32'd1);
        check("fill_head",  32'(pix_data),   32'd0);
        check("fill_sof",   32'(pix_sof),    32'd1);
        pix_ready = 1'b1;
        @(posedge clk); #1;
        pix_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("refill_acks",  32'(n_acks),     32'd257);
        check("refill_level", 32'(fifo_level), 32'd256);
        check("refill_cyc",   32'(wb_cyc),     32'd0);
        check("refill_head",  32'(pix_data),   32'd1);

        // ---------------- Slow slave, enable dropped mid-transfer ----------------
        apply_reset(1'b0, 1'b1, 5);
        repeat (2) @(posedge clk);
        #1;
        check("disabled_stb", 32'(wb_stb), 32'd0);
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        stb_cycles = 0;
        for (int i = 0; i < 20 && n_acks == 0; i++) begin
            check("hold_stb", 32'(wb_stb), 32'd1);
            check("hold_adr", wb_adr,      32'd0);
            stb_cycles++;
            @(posedge clk); #1;
        end
        check("slow_acks",      32'(n_acks),     32'd1);
        check("slow_stb_cycles", 32'(stb_cycles), 32'd6);
        check("drop_stb",       32'(wb_stb),     32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("idle_stb",  32'(wb_stb), 32'd0);
        check("idle_acks", 32'(n_acks), 32'd1);
        enable = 1'b1;
        @(posedge clk); #1;
        check("resume_stb", 32'(wb_stb), 32'd1);
        check("resume_adr", wb_adr,      32'd2);
        for (int i = 0; i < 20 && n_acks == 1; i++) begin
            @(posedge clk); #1;
        end
        check("resume_acks", 32'(n_acks), 32'd2);
        repeat (2) @(posedge clk);
        #1;
        check("mid_stb", 32'(wb_stb), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_cyc",   32'(wb_cyc),     32'd0);
        check("async_level", 32'(fifo_level), 32'd0);
        check("async_valid", 32'(pix_valid),  32'd0);
        check("async_adr",   wb_adr,          32'd0);

        // ---------------- Arbitration pauses over a long burst ----------------
        apply_reset(1'b1, 1'b1, 0);
        @(posedge clk); #1;
        check("burst_stb", 32'(wb_stb), 32'd1);
        n_cyc_low = 0;
        repeat (200) @(posedge clk);
        #1;
`ifdef FB_READER_FAIRPLAY_EN
        check("burst_low_cycles", 32'(n_cyc_low), 32'd3);
        check("burst_acks",       32'(n_acks),    32'd197);
`else
        check("burst_low_cycles", 32'(n_cyc_low), 32'd0);
        check("burst_acks",       32'(n_acks),    32'd200);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
